cart_loader: RTL and testbench



---
 rtl/cart_loader.sv | 114 +++++++++++
 tb/tb_cart_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_loader.sv
// Cartridge download front-end: one toggle-handshaked SDRAM write per ioctl byte, plus ROM mask/header/GG bookkeeping.
// Write issues 1 cycle after ioctl_wr; ioctl_wait stays high from accept until the sdram ack toggle returns.
module cart_loader #(
  parameter int ADDR_W   = 22,
  parameter int HDR_SIZE = 512
) (
  input  logic              clk_sys,
  input  logic              RESET_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              cart_download,
  output logic              code_download,
  output logic              rom_wr,
  input  logic              we_ack,
  output logic [23:0]       romwr_a,
  output logic [7:0]        rom_din,
  output logic [ADDR_W-1:0] cart_mask,
  output logic [ADDR_W-1:0] cart_mask512,
  output logic              cart_sz512,
  output logic              gg,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_PEND, S_FLUSH} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_cart_dl_q;
  logic [9:0]        r_cnt;
  logic              w_start;
  logic              w_accept;
  logic              w_acked;
  logic              w_hdr_hit;
  logic [ADDR_W-1:0] w_addr_off;

  assign cart_download = ioctl_download & ~&ioctl_index;
  assign code_download = ioctl_download &  &ioctl_index;

  assign w_start    = (r_state == S_IDLE) & cart_download & ~r_cart_dl_q;
  assign w_accept   = (r_state == S_ACCEPT) & ioctl_wr & cart_download;
  assign w_acked    = (r_state == S_PEND) & (we_ack == rom_wr);
  assign w_hdr_hit  = (ioctl_addr >= 25'(HDR_SIZE));
  // Subtracting in the truncated width gives the same low bits as the full-width offset.
  assign w_addr_off = ioctl_addr[ADDR_W-1:0] - ADDR_W'(HDR_SIZE);

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_ACCEPT;
      S_ACCEPT: begin
        if (w_accept)           w_next = S_PEND;
        else if (!cart_download) w_next = S_FLUSH;
      end
      // A falling download is only honoured once the outstanding write is acked.
      S_PEND:   if (w_acked) w_next = cart_download ? S_ACCEPT : S_FLUSH;
      S_FLUSH:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      r_cart_dl_q  <= 1'b0;
      r_cnt        <= '0;
      ioctl_wait   <= 1'b0;
      rom_wr       <= 1'b0;
      romwr_a      <= '0;
      rom_din      <= '0;
      cart_mask    <= '0;
      cart_mask512 <= '0;
      cart_sz512   <= 1'b0;
      gg           <= 1'b0;
      done         <= 1'b0;
    end else begin
      r_cart_dl_q <= cart_download;
      done        <= (r_state == S_FLUSH);

      if (w_start) begin
        romwr_a      <= '0;
        r_cnt        <= '0;
        cart_mask    <= '0;
        cart_mask512 <= '0;
      end

      if (w_accept) begin
        rom_din    <= ioctl_dout;
        rom_wr     <= ~rom_wr;
        ioctl_wait <= 1'b1;
        cart_mask  <= cart_mask | ioctl_addr[ADDR_W-1:0];
        if (w_hdr_hit) cart_mask512 <= cart_mask512 | w_addr_off;
        gg         <= (ioctl_index[4:0] == 5'd2);
      end

      if (w_acked) begin
        ioctl_wait <= 1'b0;
        romwr_a    <= romwr_a + 24'd1;
        r_cnt      <= r_cnt + 10'd1;
      end

      // Only the byte count modulo 1024 matters for copier-header detection.
      if (r_state == S_FLUSH) cart_sz512 <= (r_cnt == 10'd512);
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: table of whole downloads checked at the end, a scoreboard of queued writes
// matched against each rom_wr toggle, and hand sequences for code download and reset mid-write.
module tb_cart_loader;

  localparam int ADDR_W = 22;

  logic              clk_sys = 1'b0;
  logic              RESET_n = 1'b0;
  logic              ioctl_download = 1'b0;
  logic [7:0]        ioctl_index = 8'h00;
  logic              ioctl_wr = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = '0;
  logic              ioctl_wait;
  logic              cart_download;
  logic              code_download;
  logic              rom_wr;
  logic              we_ack = 1'b0;
  logic [23:0]       romwr_a;
  logic [7:0]        rom_din;
  logic [ADDR_W-1:0] cart_mask;
  logic [ADDR_W-1:0] cart_mask512;
  logic              cart_sz512;
  logic              gg;
  logic              done;

  cart_loader #(.ADDR_W(ADDR_W), .HDR_SIZE(512)) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .cart_download(cart_download), .code_download(code_download),
    .rom_wr(rom_wr), .we_ack(we_ack), .romwr_a(romwr_a), .rom_din(rom_din),
    .cart_mask(cart_mask), .cart_mask512(cart_mask512), .cart_sz512(cart_sz512),
    .gg(gg), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [23:0] a;
    logic [7:0]  d;
  } exp_t;

  typedef struct {
    logic [7:0]        idx;
    int                nbytes;
    int                delay;
    bit                drop_early;
    logic [ADDR_W-1:0] e_mask;
    logic [ADDR_W-1:0] e_mask512;
    logic              e_sz;
    logic              e_gg;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ack_delay = 1;
  bit   resync = 1'b1;
  int   toggles = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   last_ack_edge = 0;
  int   last_done_edge = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // sdram write-port model: pops the scoreboard on every toggle, acks after ack_delay cycles
  initial begin : sdram_model
    logic prev;
    bit   pending;
    int   cd;
    exp_t cur;
    prev = 1'b0; pending = 1'b0; cd = 0;
    cur = '{a: '0, d: '0};
    forever begin
      @(posedge clk_sys);
      #1;
      if (resync) begin
        we_ack  = rom_wr;
        prev    = rom_wr;
        pending = 1'b0;
        resync  = 1'b0;
      end else begin
        if (rom_wr != prev) begin
          prev = rom_wr;
          toggles++;
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_toggle: rom_wr toggled to %0b with no write queued, expected no toggle", rom_wr);
          end else begin
            cur = sb.pop_front();
            chk("romwr_a", 32'(romwr_a), 32'(cur.a));
            chk("rom_din", 32'(rom_din), 32'(cur.d));
          end
          pending = 1'b1;
          cd = ack_delay;
        end
        if (pending) begin
          if (cd <= 1) begin
            chk("romwr_a_stable", 32'(romwr_a), 32'(cur.a));
            chk("rom_din_stable", 32'(rom_din), 32'(cur.d));
            we_ack = rom_wr;
            pending = 1'b0;
            last_ack_edge = cyc + 1;
          end else begin
            cd--;
          end
        end
      end
    end
  end

  initial begin : done_monitor
    forever begin
      @(posedge clk_sys);
      cyc++;
      #1;
      if (done) begin
        done_cnt++;
        last_done_edge = cyc;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_not_busy(input string nm);
    int w;
    w = 0;
    while (ioctl_wait && w < 300) begin
      tick();
      w++;
    end
    chk(nm, 32'(ioctl_wait), 32'd0);
  endtask

  task automatic write_byte(input logic [24:0] addr, input logic [7:0] d, input bit cart);
    if (ioctl_wait) wait_not_busy("wait_timeout");
    ioctl_addr = addr;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (cart) sb.push_back('{a: addr[23:0], d: d});
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic run_dl(input vec_t v, input string tag);
    int d0, t0, w;
    sb.delete();
    ack_delay = v.delay;
    ioctl_index = v.idx;
    d0 = done_cnt;
    t0 = toggles;
    ioctl_download = 1'b1;
    tick(2);
    chk({tag, "_cart_download"}, 32'(cart_download), 32'd1);
    chk({tag, "_code_download"}, 32'(code_download), 32'd0);
    for (int i = 0; i < v.nbytes; i++)
      write_byte(25'(i), 8'(i) ^ v.idx, 1'b1);
    if (!v.drop_early) wait_not_busy({tag, "_final_wait"});
    ioctl_download = 1'b0;
    w = 0;
    while (done_cnt == d0 && w < 200) begin
      tick();
      w++;
    end
    tick(3);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_toggles"}, 32'(toggles - t0), 32'(v.nbytes));
    chk({tag, "_romwr_a"}, 32'(romwr_a), 32'(v.nbytes));
    chk({tag, "_cart_mask"}, 32'(cart_mask), 32'(v.e_mask));
    chk({tag, "_cart_mask512"}, 32'(cart_mask512), 32'(v.e_mask512));
    chk({tag, "_cart_sz512"}, 32'(cart_sz512), 32'(v.e_sz));
    chk({tag, "_gg"}, 32'(gg), 32'(v.e_gg));
    chk({tag, "_wait_idle"}, 32'(ioctl_wait), 32'd0);
    chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    if (v.drop_early)
      chk({tag, "_done_after_ack"}, 32'(last_done_edge), 32'(last_ack_edge + 1));
  endtask

  initial begin : stim
    vec_t vt[4];
    vec_t vr;
    int t0, d0;
    logic [ADDR_W-1:0] m0, m1;
    logic g0, rw0;

    vt[0] = '{8'h01, 1024,  3, 1'b0, 22'h3FF, 22'h1FF, 1'b0, 1'b0};
    vt[1] = '{8'h02, 2560,  1, 1'b0, 22'hFFF, 22'h7FF, 1'b1, 1'b1};
    vt[2] = '{8'h01,  256,  2, 1'b0, 22'h0FF, 22'h000, 1'b0, 1'b0};
    vt[3] = '{8'h42,  600, 10, 1'b1, 22'h3FF, 22'h07F, 1'b0, 1'b1};

    tick(3);
    chk("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_rom_wr", 32'(rom_wr), 32'd0);
    chk("rst_romwr_a", 32'(romwr_a), 32'd0);
    chk("rst_rom_din", 32'(rom_din), 32'd0);
    chk("rst_masks", 32'(cart_mask | cart_mask512), 32'd0);
    chk("rst_flags", 32'({cart_sz512, gg, done}), 32'd0);
    RESET_n = 1'b1;
    tick(2);

    for (int k = 0; k < 4; k++)
      run_dl(vt[k], $sformatf("vec%0d", k));

    // code download must leave the SDRAM path and bookkeeping untouched
    ioctl_index = 8'hFF;
    t0 = toggles; d0 = done_cnt;
    m0 = cart_mask; m1 = cart_mask512; g0 = gg; rw0 = rom_wr;
    ioctl_download = 1'b1;
    tick();
    chk("code_code_download", 32'(code_download), 32'd1);
    chk("code_cart_download", 32'(cart_download), 32'd0);
    for (int i = 0; i < 16; i++) begin
      write_byte(25'(i), 8'(i), 1'b0);
      chk("code_wait_low", 32'(ioctl_wait), 32'd0);
    end
    ioctl_download = 1'b0;
    tick(4);
    chk("code_toggles", 32'(toggles - t0), 32'd0);
    chk("code_rom_wr", 32'(rom_wr), 32'(rw0));
    chk("code_cart_mask", 32'(cart_mask), 32'(m0));
    chk("code_cart_mask512", 32'(cart_mask512), 32'(m1));
    chk("code_gg", 32'(gg), 32'(g0));
    chk("code_no_done", 32'(done_cnt - d0), 32'd0);

    // reset asserted while byte 100 is still waiting for its ack
    sb.delete();
    ack_delay = 20;
    ioctl_index = 8'h01;
    ioctl_download = 1'b1;
    tick(2);
    for (int i = 0; i <= 100; i++)
      write_byte(25'(i), 8'(i) ^ 8'h01, 1'b1);
    tick();
    chk("pend_wait_high", 32'(ioctl_wait), 32'd1);
    @(posedge clk_sys);
    #3;
    RESET_n = 1'b0;
    resync = 1'b1;
    #1;
    chk("arst_ioctl_wait", 32'(ioctl_wait), 32'd0);
    chk("arst_romwr_a", 32'(romwr_a), 32'd0);
    chk("arst_cart_mask", 32'(cart_mask), 32'd0);
    chk("arst_cart_mask512", 32'(cart_mask512), 32'd0);
    chk("arst_rom_wr", 32'(rom_wr), 32'd0);
    ioctl_download = 1'b0;
    sb.delete();
    tick(2);
    RESET_n = 1'b1;
    tick(2);
    vr = '{8'h01, 64, 2, 1'b0, 22'h03F, 22'h000, 1'b0, 1'b0};
    run_dl(vr, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
